br_ctrl: RTL and testbench



---
 rtl/br_ctrl_if.sv | 40 ++++
 rtl/br_ctrl.sv | 107 ++++++++++
 tb/tb_br_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/br_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : br_ctrl_if
// Description : Control/status bundle between the main control FSM and the
//               branch-resolution controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_ctrl_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 start;
   logic [15:0]          ir;
   logic                 ld_cc;
   logic                 n_flag;
   logic                 z_flag;
   logic                 p_flag;
   logic                 clr_cnt;
   logic                 busy;
   logic                 done;
   logic                 taken;
   logic                 ld_pc;
   logic [1:0]           pcmux_sel;
   logic                 addr1mux_sel;
   logic [1:0]           addr2mux_sel;
   logic [CNT_WIDTH-1:0] taken_cnt;
   logic [CNT_WIDTH-1:0] nottaken_cnt;

   modport master (
      output start, ir, ld_cc, n_flag, z_flag, p_flag, clr_cnt,
      input  busy, done, taken, ld_pc, pcmux_sel, addr1mux_sel, addr2mux_sel,
             taken_cnt, nottaken_cnt
   );

   modport slave (
      input  start, ir, ld_cc, n_flag, z_flag, p_flag, clr_cnt,
      output busy, done, taken, ld_pc, pcmux_sel, addr1mux_sel, addr2mux_sel,
             taken_cnt, nottaken_cnt
   );
endinterface
`default_nettype wire

// File: rtl/br_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : br_ctrl
// Description : SLC-3 BR resolution: waits out condition-code loads, tests the
//               nzp mask, drives the PC load path and keeps taken statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module br_ctrl #(
   parameter int CNT_WIDTH = 16
) (
   input  wire logic  clk,
   input  wire logic  reset,
   br_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_CC = 3'd1,
      S_EVAL    = 3'd2,
      S_LOAD_PC = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic [15:0]          ir_q, ir_d;
   logic                 taken_q, taken_d;
   logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_WIDTH-1:0] nottaken_cnt_q, nottaken_cnt_d;
   logic                 cond;

   assign cond = (ir_q[11] & bus.n_flag) | (ir_q[10] & bus.z_flag) | (ir_q[9] & bus.p_flag);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         ir_q           <= '0;
         taken_q        <= 1'b0;
         taken_cnt_q    <= '0;
         nottaken_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         ir_q           <= ir_d;
         taken_q        <= taken_d;
         taken_cnt_q    <= taken_cnt_d;
         nottaken_cnt_q <= nottaken_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      taken_d = taken_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ir_d = bus.ir;
               if (bus.ir[15:12] == 4'b0000) begin
                  state_d = bus.ld_cc ? S_WAIT_CC : S_EVAL;
               end else begin
                  state_d = S_DONE;
                  taken_d = 1'b0;
               end
            end
         end
         // Flags written by an in-flight ld_cc are only readable a cycle later.
         S_WAIT_CC: begin
            if (!bus.ld_cc) state_d = S_EVAL;
         end
         S_EVAL: begin
            taken_d = cond;
            state_d = cond ? S_LOAD_PC : S_DONE;
         end
         S_LOAD_PC: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_comb begin
      taken_cnt_d    = taken_cnt_q;
      nottaken_cnt_d = nottaken_cnt_q;
      if (bus.clr_cnt) begin
         taken_cnt_d    = '0;
         nottaken_cnt_d = '0;
      end else if (state_q == S_EVAL) begin
         if (cond && taken_cnt_q != CNT_MAX)
            taken_cnt_d = taken_cnt_q + 1'b1;
         else if (!cond && nottaken_cnt_q != CNT_MAX)
            nottaken_cnt_d = nottaken_cnt_q + 1'b1;
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = (state_q == S_DONE);
   assign bus.taken        = (state_q == S_DONE) & taken_q;
   assign bus.ld_pc        = (state_q == S_LOAD_PC);
   assign bus.pcmux_sel    = (state_q == S_LOAD_PC) ? 2'b01 : 2'b00;
   assign bus.addr1mux_sel = 1'b0;
   assign bus.addr2mux_sel = (state_q == S_LOAD_PC) ? 2'b10 : 2'b00;
   assign bus.taken_cnt    = taken_cnt_q;
   assign bus.nottaken_cnt = nottaken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_br_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_ctrl
// Description : Directed self-checking bench for br_ctrl (4-bit counters so
//               saturation is reachable in a short run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_ctrl;
   localparam int CW = 4;

   // {busy, done, taken, ld_pc, pcmux_sel, addr1mux_sel, addr2mux_sel}
   localparam logic [8:0] O_IDLE   = 9'b0000_00_0_00;
   localparam logic [8:0] O_BUSY   = 9'b1000_00_0_00;
   localparam logic [8:0] O_LDPC   = 9'b1001_01_0_10;
   localparam logic [8:0] O_DONE_T = 9'b1110_00_0_00;
   localparam logic [8:0] O_DONE_N = 9'b1100_00_0_00;

   logic clk;
   logic reset;
   int   vectors;
   int   errors;

   br_ctrl_if #(.CNT_WIDTH(CW)) bus ();

   br_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [8:0] outs;
   assign outs = {bus.busy, bus.done, bus.taken, bus.ld_pc, bus.pcmux_sel,
                  bus.addr1mux_sel, bus.addr2mux_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_flags(input logic n, input logic z, input logic p);
      bus.n_flag = n;
      bus.z_flag = z;
      bus.p_flag = p;
   endtask

   // Unchecked taken BRz with Z=1: start, EVAL, LOAD_PC, DONE.
   task automatic run_taken();
      set_flags(1'b0, 1'b1, 1'b0);
      bus.start = 1'b1;
      bus.ir    = 16'h0400;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      reset   = 1'b1;
      bus.start = 1'b0; bus.ir = 16'h0000; bus.ld_cc = 1'b0; bus.clr_cnt = 1'b0;
      set_flags(1'b0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b0;
      check("reset_outs", outs, O_IDLE);
      check("reset_tcnt", bus.taken_cnt, 0);
      check("reset_ncnt", bus.nottaken_cnt, 0);

      // BRz taken, no hazard; ir scrambled after capture
      set_flags(1'b0, 1'b1, 1'b0);
      bus.start = 1'b1; bus.ir = 16'h0403;
      tick();
      bus.start = 1'b0; bus.ir = 16'hFFFF;
      check("brz_c1", outs, O_BUSY);
      bus.ir = 16'h0000;
      tick();
      check("brz_c2_ldpc", outs, O_LDPC);
      check("brz_c2_tcnt", bus.taken_cnt, 1);
      tick();
      check("brz_c3_done", outs, O_DONE_T);
      tick();
      check("brz_c4_idle", outs, O_IDLE);

      // BRn not taken with P=1
      set_flags(1'b0, 1'b0, 1'b1);
      bus.start = 1'b1; bus.ir = 16'h0805;
      tick();
      bus.start = 1'b0;
      check("brn_c1", outs, O_BUSY);
      tick();
      check("brn_c2_done", outs, O_DONE_N);
      check("brn_c2_ncnt", bus.nottaken_cnt, 1);
      check("brn_c2_tcnt", bus.taken_cnt, 1);
      tick();
      check("brn_c3_idle", outs, O_IDLE);

      // Hazard: ld_cc in start cycle; flags become N=1 next cycle
      set_flags(1'b0, 1'b1, 1'b0);
      bus.start = 1'b1; bus.ir = 16'h0801; bus.ld_cc = 1'b1;
      tick();
      bus.start = 1'b0; bus.ld_cc = 1'b0;
      set_flags(1'b1, 1'b0, 1'b0);
      check("haz_c1_wait", outs, O_BUSY);
      tick();
      check("haz_c2_eval", outs, O_BUSY);
      check("haz_c2_tcnt", bus.taken_cnt, 1);
      tick();
      check("haz_c3_ldpc", outs, O_LDPC);
      check("haz_c3_tcnt", bus.taken_cnt, 2);
      tick();
      check("haz_c4_done", outs, O_DONE_T);
      tick();
      check("haz_c5_idle", outs, O_IDLE);

      // Non-BR opcode (ADD)
      bus.start = 1'b1; bus.ir = 16'h1021;
      tick();
      bus.start = 1'b0;
      check("add_c1_done", outs, O_DONE_N);
      check("add_c1_tcnt", bus.taken_cnt, 2);
      check("add_c1_ncnt", bus.nottaken_cnt, 1);
      tick();
      check("add_c2_idle", outs, O_IDLE);

      // Start pulses while busy are dropped
      set_flags(1'b0, 1'b1, 1'b0);
      bus.start = 1'b1; bus.ir = 16'h0400;
      tick();
      bus.ir = 16'h1021;
      check("ign_c1", outs, O_BUSY);
      tick();
      check("ign_c2_ldpc", outs, O_LDPC);
      tick();
      bus.start = 1'b0;
      check("ign_c3_done", outs, O_DONE_T);
      tick();
      check("ign_c4_idle", outs, O_IDLE);
      tick();
      check("ign_c5_idle", outs, O_IDLE);
      check("ign_tcnt", bus.taken_cnt, 3);

      // Mask 000 never taken even with every flag set
      set_flags(1'b1, 1'b1, 1'b1);
      bus.start = 1'b1; bus.ir = 16'h0000;
      tick();
      bus.start = 1'b0;
      tick();
      check("m000_done", outs, O_DONE_N);
      check("m000_ncnt", bus.nottaken_cnt, 2);
      tick();

      // Mask 111 taken, same path
      set_flags(1'b0, 1'b0, 1'b1);
      bus.start = 1'b1; bus.ir = 16'h0E00;
      tick();
      bus.start = 1'b0;
      check("m111_c1", outs, O_BUSY);
      tick();
      check("m111_c2_ldpc", outs, O_LDPC);
      tick();
      check("m111_c3_done", outs, O_DONE_T);
      check("m111_tcnt", bus.taken_cnt, 4);
      tick();

      // Drive taken_cnt to all-ones, then one more must hold
      for (int i = 0; i < 11; i++) run_taken();
      check("sat_full", bus.taken_cnt, 15);
      bus.start = 1'b1; bus.ir = 16'h0400;
      tick();
      bus.start = 1'b0;
      tick();
      check("sat_ldpc", outs, O_LDPC);
      check("sat_hold", bus.taken_cnt, 15);
      tick(); tick();

      // Clear coincident with EVAL increment
      bus.start = 1'b1; bus.ir = 16'h0400;
      tick();
      bus.start = 1'b0; bus.clr_cnt = 1'b1;
      tick();
      bus.clr_cnt = 1'b0;
      check("clr_ldpc", outs, O_LDPC);
      check("clr_tcnt", bus.taken_cnt, 0);
      check("clr_ncnt", bus.nottaken_cnt, 0);
      tick();
      check("clr_done", outs, O_DONE_T);
      tick();

      // Reset during LOAD_PC aborts the branch
      run_taken();
      check("rst_pre_tcnt", bus.taken_cnt, 1);
      bus.start = 1'b1; bus.ir = 16'h0400;
      tick();
      bus.start = 1'b0;
      tick();
      check("rst_ldpc", outs, O_LDPC);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_c3_outs", outs, O_IDLE);
      check("rst_c3_tcnt", bus.taken_cnt, 0);
      check("rst_c3_ncnt", bus.nottaken_cnt, 0);
      tick();
      check("rst_c4_outs", outs, O_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire
